// File: rtl/lif_host_pkg.sv
// Shared types and constants for the LIF neuron host driver: FSM encoding,
// config register map and CFG slot schedule.
package lif_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NRST  = 3'd1,
    S_CFG   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int N_CFG = 11;

  localparam logic [3:0] ADDR_E_REST = 4'd0;
  localparam logic [3:0] ADDR_E_TAU  = 4'd1;
  localparam logic [3:0] ADDR_V_TH   = 4'd2;
  localparam logic [3:0] ADDR_VINIT0 = 4'd3;
  localparam logic [3:0] ADDR_LAST   = 4'd10;

  localparam logic [3:0] SLOT_E_REST = 4'd2;
  localparam logic [3:0] SLOT_VINIT0 = 4'd5;
  localparam logic [3:0] CFG_LAST    = 4'd12;

  // Config register address driven during a CFG slot (valid for slots 2..12).
  function automatic logic [3:0] slot_addr(input logic [3:0] slot);
    if (slot < SLOT_VINIT0) return ADDR_E_REST + (slot - SLOT_E_REST);
    return ADDR_VINIT0 + (slot - SLOT_VINIT0);
  endfunction

endpackage

// File: rtl/lif_result_fifo.sv
// Count-based first-word-fall-through FIFO for captured neuron results.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module lif_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lif_host_driver.sv
// Host-side sequencer for a LIF neuron tile: resets it, shifts in config words,
// streams input current and buffers the neuron's outputs into a result FIFO.
module lif_host_driver
  import lif_host_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        start,
  input  logic [15:0] run_len,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  cur_data,
  input  logic        cur_valid,
  output logic        cur_ready,
  output logic        nrn_rst,
  output logic [7:0]  nrn_ui,
  output logic [7:0]  nrn_uio,
  input  logic [7:0]  nrn_uo,
  input  logic [7:0]  nrn_uio_out,
  input  logic [7:0]  nrn_uio_oe,
  output logic [14:0] res_data,
  output logic        res_spike,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] spike_cnt,
  output logic        ovf,
  output state_t      dbg_state
);

  state_t      state;
  logic [15:0] cfg_mem [N_CFG];
  logic [15:0] nrst_cnt;
  logic [15:0] run_len_q;
  logic [15:0] run_cnt;
  logic [3:0]  slot;
  logic [15:0] slot_word;
  logic [15:0] fifo_head;
  logic        fifo_empty;
  logic        fifo_drop;
  logic        push;
  logic        pop;
  logic        go;
  logic        unused_oe;

  // Only oe bit 0 (the neuron's run flag) carries meaning for the host.
  assign unused_oe = ^nrn_uio_oe[7:1];

  assign go        = (state == S_IDLE) && start;
  assign push      = (state == S_RUN) && nrn_uio_oe[0];
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;
  assign slot_word = (slot < SLOT_E_REST) ? 16'h0000 : cfg_mem[slot_addr(slot)];

  // Result stream: res_valid means a word is offered; the word transfers on a
  // cycle with res_valid && res_ready, and holds steady while res_ready is low.
  assign res_valid = !fifo_empty;
  assign pop       = res_valid && res_ready;
  assign res_data  = fifo_head[15:1];
  assign res_spike = fifo_head[0];

  lif_result_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({nrn_uo, nrn_uio_out}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_comb begin
    nrn_rst   = 1'b1;
    nrn_ui    = 8'h00;
    nrn_uio   = 8'h00;
    cur_ready = 1'b0;
    case (state)
      S_CFG: begin
        nrn_rst           = 1'b0;
        {nrn_ui, nrn_uio} = slot_word;
      end
      S_RUN: begin
        nrn_rst   = 1'b0;
        cur_ready = 1'b1;
        nrn_ui    = cur_valid ? cur_data : 8'h00;
      end
      S_DRAIN: nrn_rst = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      nrst_cnt  <= '0;
      slot      <= '0;
      run_len_q <= '0;
      run_cnt   <= '0;
      spike_cnt <= '0;
      ovf       <= 1'b0;
      for (int i = 0; i < N_CFG; i++) cfg_mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_we && cfg_addr <= ADDR_LAST) cfg_mem[cfg_addr] <= cfg_wdata;
          if (start) begin
            run_len_q <= run_len;
            nrst_cnt  <= '0;
            state     <= (run_len == 16'd0) ? S_DONE : S_NRST;
          end
        end
        S_NRST: begin
          if (nrst_cnt == 16'(RST_CYCLES - 1)) begin
            slot  <= '0;
            state <= S_CFG;
          end else begin
            nrst_cnt <= nrst_cnt + 16'd1;
          end
        end
        S_CFG: begin
          if (slot == CFG_LAST) begin
            run_cnt <= run_len_q;
            state   <= S_RUN;
          end else begin
            slot <= slot + 4'd1;
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt - 16'd1;
          if (run_cnt == 16'd1) state <= S_DRAIN;
        end
        S_DRAIN: if (fifo_empty) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (go) begin
        spike_cnt <= '0;
        ovf       <= 1'b0;
      end else begin
        if (fifo_drop) ovf <= 1'b1;
        if (push && nrn_uio_out[0] && spike_cnt != 16'hFFFF) spike_cnt <= spike_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lif_host_driver.sv
// Directed bench for lif_host_driver: drives jobs cycle by cycle, models the
// result FIFO occupancy, and checks results through a queue-based monitor.
module tb_lif_host_driver;
  import lif_host_pkg::*;

  localparam int DEPTH = 4;
  localparam int RST   = 2;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        start;
  logic [15:0] run_len;
  logic        busy;
  logic        done;
  logic [7:0]  cur_data;
  logic        cur_valid;
  logic        cur_ready;
  logic        nrn_rst;
  logic [7:0]  nrn_ui;
  logic [7:0]  nrn_uio;
  logic [7:0]  nrn_uo;
  logic [7:0]  nrn_uio_out;
  logic [7:0]  nrn_uio_oe;
  logic [14:0] res_data;
  logic        res_spike;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] spike_cnt;
  logic        ovf;
  state_t      dbg_state;

  logic [15:0] exp_q[$];
  logic [15:0] exp_cfg [11];
  int          n_checks;
  int          n_errors;

  lif_host_driver #(.FIFO_DEPTH(DEPTH), .RST_CYCLES(RST)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .run_len(run_len), .busy(busy), .done(done),
    .cur_data(cur_data), .cur_valid(cur_valid), .cur_ready(cur_ready),
    .nrn_rst(nrn_rst), .nrn_ui(nrn_ui), .nrn_uio(nrn_uio),
    .nrn_uo(nrn_uo), .nrn_uio_out(nrn_uio_out), .nrn_uio_oe(nrn_uio_oe),
    .res_data(res_data), .res_spike(res_spike), .res_valid(res_valid), .res_ready(res_ready),
    .spike_cnt(spike_cnt), .ovf(ovf), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endfunction

  function automatic logic [15:0] cfg_word(input int s);
    if (s < 2) return 16'h0000;
    return exp_cfg[s - 2];
  endfunction

  // Scoreboard monitor: the FIFO head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {res_data, res_spike}, 16'h0000);
      end else begin
        chk("result", {res_data, res_spike}, exp_q[0]);
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_junk(input logic oe_on);
    nrn_uio_oe  = oe_on ? 8'hFF : 8'h00;
    nrn_uo      = 8'hEE;
    nrn_uio_out = 8'h55;
    cur_valid   = 1'b1;
    cur_data    = 8'h99;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (a <= 4'd10) exp_cfg[a] = d;
  endtask

  task automatic run_job(input int len, input int ncur, input logic [7:0] cur_byte,
                         input logic oe_on, input logic [15:0] mask, input int rdy_from,
                         input int drain_hold, input int abort_slot);
    int   n_spk;
    logic exp_ovf;
    bit   got;
    n_spk = 0; exp_ovf = 1'b0; got = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; run_len = 16'(len);
    @(negedge clk); #1;
    chk("idle_busy", busy, 0);
    if (len == 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 1);
      chk("zero_nrn_rst", nrn_rst, 1);
      chk("zero_nrn_ui", {nrn_ui, nrn_uio}, 0);
      chk("zero_spike_cnt", spike_cnt, 0);
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("zero_done_end", done, 0);
      chk("zero_busy_end", busy, 0);
      chk("zero_nrn_rst_end", nrn_rst, 1);
      return;
    end
    for (int i = 0; i < RST; i++) begin
      @(posedge clk); #1;
      start = (i == 1); run_len = 16'd0;
      cfg_we = (i == 0); cfg_addr = ADDR_E_REST; cfg_wdata = 16'hDEAD;
      drive_junk(oe_on);
      @(negedge clk); #1;
      chk("nrst_rst", nrn_rst, 1);
      chk("nrst_ui_uio", {nrn_ui, nrn_uio}, 0);
      chk("nrst_busy", busy, 1);
      chk("nrst_cur_ready", cur_ready, 0);
      chk("nrst_done", done, 0);
      if (i == 0) begin
        chk("start_clr_spike_cnt", spike_cnt, 0);
        chk("start_clr_ovf", ovf, 0);
      end
    end
    for (int s = 0; s <= 12; s++) begin
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0;
      drive_junk(oe_on);
      if (s == abort_slot) rst = 1'b1;
      @(negedge clk); #1;
      chk("cfg_nrn_rst", nrn_rst, 0);
      chk("cfg_word", {nrn_ui, nrn_uio}, cfg_word(s));
      chk("cfg_busy", busy, 1);
      chk("cfg_cur_ready", cur_ready, 0);
      if (s == abort_slot) begin
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("abort_state", dbg_state, S_IDLE);
        chk("abort_nrn_rst", nrn_rst, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ui_uio", {nrn_ui, nrn_uio}, 0);
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          @(negedge clk); #1;
          chk("abort_no_done", done, 0);
        end
        for (int a = 0; a < 11; a++) exp_cfg[a] = 16'h0000;
        return;
      end
    end
    for (int r = 0; r < len; r++) begin
      @(posedge clk); #1;
      cur_valid = (r < ncur); cur_data = cur_byte;
      res_ready = (r >= rdy_from);
      nrn_uio_oe  = oe_on ? 8'hFF : 8'h00;
      nrn_uo      = 8'h80 + 8'(r);
      nrn_uio_out = {7'(r * 5 + 3), mask[r]};
      if (oe_on) begin
        if (mask[r]) n_spk++;
        if (exp_q.size() < DEPTH || (res_ready && exp_q.size() > 0))
          exp_q.push_back({nrn_uo, nrn_uio_out});
        else
          exp_ovf = 1'b1;
      end
      @(negedge clk); #1;
      chk("run_cur_ready", cur_ready, 1);
      chk("run_nrn_ui", nrn_ui, (r < ncur) ? cur_byte : 8'h00);
      chk("run_nrn_uio", nrn_uio, 0);
      chk("run_nrn_rst", nrn_rst, 0);
      chk("run_done", done, 0);
    end
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #1;
      drive_junk(oe_on);
      cur_data = 8'hAA;
      res_ready = (k >= drain_hold);
      @(negedge clk); #1;
      if (done) begin
        got = 1'b1;
      end else begin
        chk("drain_cur_ready", cur_ready, 0);
        chk("drain_nrn_ui", nrn_ui, 0);
        chk("drain_busy", busy, 1);
      end
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("done_after_drain", exp_q.size(), 0);
      chk("done_busy", busy, 1);
      chk("spike_cnt", spike_cnt, n_spk);
      chk("ovf", ovf, exp_ovf);
    end
    @(posedge clk); #1;
    cur_valid = 1'b0; nrn_uio_oe = 8'h00; res_ready = 1'b1;
    @(negedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_busy_after", busy, 0);
    chk("ovf_held", ovf, exp_ovf);
    chk("idle_nrn_rst", nrn_rst, 1);
    chk("idle_res_valid", res_valid, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; run_len = '0;
    cur_data = '0; cur_valid = 1'b0; nrn_uo = '0; nrn_uio_out = '0; nrn_uio_oe = '0;
    res_ready = 1'b0;
    for (int a = 0; a < 11; a++) exp_cfg[a] = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_ready", cur_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_spike_cnt", spike_cnt, 0);
    chk("rst_nrn_rst", nrn_rst, 1);
    chk("rst_nrn_ui_uio", {nrn_ui, nrn_uio}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    cfg_write(ADDR_E_REST, 16'hC400);
    cfg_write(ADDR_E_TAU, 16'h018E);
    cfg_write(ADDR_V_TH, 16'h3C00);
    for (int k = 0; k < 8; k++) cfg_write(ADDR_VINIT0 + 4'(k), 16'(k));
    cfg_write(4'd11, 16'hBEEF);
    cfg_write(4'd15, 16'hBEEF);

    // Config replay and current streaming, no captures.
    run_job(4, 3, 8'h20, 1'b0, 16'h0000, 0, 0, -1);
    // Five spiking captures drained immediately.
    run_job(5, 0, 8'h00, 1'b1, 16'hFFFF, 0, 0, -1);
    // Six captures into a stalled 4-deep FIFO: two drop, ovf set.
    run_job(6, 0, 8'h00, 1'b1, 16'h000F, 99, 3, -1);
    // Push and pop on a full FIFO from the fifth capture on: nothing drops.
    run_job(6, 2, 8'h11, 1'b1, 16'h0025, 4, 0, -1);
    // Reset in CFG slot 7, then a replay with cleared config.
    run_job(4, 0, 8'h00, 1'b0, 16'h0000, 0, 0, 7);
    run_job(3, 1, 8'h7F, 1'b1, 16'h0007, 0, 0, -1);
    // Zero-length run.
    run_job(0, 0, 8'h00, 1'b0, 16'h0000, 0, 0, -1);

    repeat (2) @(posedge clk);
    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
